// File: rtl/qracc_sram_arbiter.sv
// Round-robin two-requester arbiter/sequencer for the QR-accelerator SRAM port; one transaction in flight, grants blocked by mac_busy_i.
// Optional grant counters enabled by defining QRACC_SRAM_ARB_GRANT_CNT_EN.
module qracc_sram_arbiter #(
  parameter int numRows = 128,
  parameter int numCols = 32,
  parameter int cntBits = 16,
  localparam int AW = $clog2(numRows)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mac_busy_i,
  input  logic               rq0_valid_i,
  input  logic               rq0_wr_i,
  input  logic [AW-1:0]      rq0_addr_i,
  input  logic [numCols-1:0] rq0_wr_data_i,
  output logic               rq0_ready_o,
  input  logic               rq1_valid_i,
  input  logic               rq1_wr_i,
  input  logic [AW-1:0]      rq1_addr_i,
  input  logic [numCols-1:0] rq1_wr_data_i,
  output logic               rq1_ready_o,
  output logic               rd0_valid_o,
  output logic [numCols-1:0] rd0_data_o,
  output logic               rd1_valid_o,
  output logic [numCols-1:0] rd1_data_o,
  output logic               sram_rq_valid_o,
  output logic               sram_rq_wr_o,
  output logic [AW-1:0]      sram_addr_o,
  output logic [numCols-1:0] sram_wr_data_o,
  input  logic               sram_rq_ready_i,
  input  logic               sram_rd_valid_i,
  input  logic [numCols-1:0] sram_rd_data_i,
  output logic               idle_o,
  output logic               err_o,
  output logic [cntBits-1:0] grant_cnt0_o,
  output logic [cntBits-1:0] grant_cnt1_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RD} state_t;

  state_t state, state_nxt;
  logic   last_grant;
  logic   owner;
  logic   grant0, grant1;
  logic   rd_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant0 || grant1) state_nxt = S_REQ;
      S_REQ:   if (sram_rq_ready_i) state_nxt = sram_rq_wr_o ? S_IDLE : S_RD;
      S_RD:    if (sram_rd_valid_i) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Tie-break favours the requester that did not win last time.
  always_comb begin
    grant0          = 1'b0;
    grant1          = 1'b0;
    sram_rq_valid_o = 1'b0;
    idle_o          = 1'b0;
    case (state)
      S_IDLE: begin
        idle_o = 1'b1;
        grant0 = !mac_busy_i && rq0_valid_i && (!rq1_valid_i || last_grant);
        grant1 = !mac_busy_i && rq1_valid_i && (!rq0_valid_i || !last_grant);
      end
      S_REQ:   sram_rq_valid_o = 1'b1;
      default: ;
    endcase
    rq0_ready_o = grant0;
    rq1_ready_o = grant1;
  end

  assign rd_done = (state == S_RD) && sram_rd_valid_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_rq_wr_o   <= 1'b0;
      sram_addr_o    <= '0;
      sram_wr_data_o <= '0;
      owner          <= 1'b0;
      last_grant     <= 1'b1;
    end else if (grant0) begin
      sram_rq_wr_o   <= rq0_wr_i;
      sram_addr_o    <= rq0_addr_i;
      sram_wr_data_o <= rq0_wr_data_i;
      owner          <= 1'b0;
      last_grant     <= 1'b0;
    end else if (grant1) begin
      sram_rq_wr_o   <= rq1_wr_i;
      sram_addr_o    <= rq1_addr_i;
      sram_wr_data_o <= rq1_wr_data_i;
      owner          <= 1'b1;
      last_grant     <= 1'b1;
    end
  end

  // Read data is registered once and steered to the owner only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd0_valid_o <= 1'b0;
      rd1_valid_o <= 1'b0;
      rd0_data_o  <= '0;
      rd1_data_o  <= '0;
      err_o       <= 1'b0;
    end else begin
      rd0_valid_o <= rd_done && !owner;
      rd1_valid_o <= rd_done && owner;
      if (rd_done && !owner) rd0_data_o <= sram_rd_data_i;
      if (rd_done && owner)  rd1_data_o <= sram_rd_data_i;
      if (sram_rd_valid_i && (state != S_RD)) err_o <= 1'b1;
    end
  end

`ifdef QRACC_SRAM_ARB_GRANT_CNT_EN
  logic [cntBits-1:0] cnt0, cnt1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (grant0 && (cnt0 != '1)) cnt0 <= cnt0 + 1'b1;
      if (grant1 && (cnt1 != '1)) cnt1 <= cnt1 + 1'b1;
    end
  end

  assign grant_cnt0_o = cnt0;
  assign grant_cnt1_o = cnt1;
`else
  assign grant_cnt0_o = '0;
  assign grant_cnt1_o = '0;
`endif

endmodule

// File: tb/tb_qracc_sram_arbiter.sv
// Directed bench for qracc_sram_arbiter: vector table of single transactions plus multi-cycle corner sequences.
module tb_qracc_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        mac_busy;
  logic        rq0_valid, rq0_wr, rq0_ready;
  logic [6:0]  rq0_addr;
  logic [31:0] rq0_wr_data;
  logic        rq1_valid, rq1_wr, rq1_ready;
  logic [6:0]  rq1_addr;
  logic [31:0] rq1_wr_data;
  logic        rd0_valid, rd1_valid;
  logic [31:0] rd0_data, rd1_data;
  logic        sram_rq_valid, sram_rq_wr, sram_rq_ready, sram_rd_valid;
  logic [6:0]  sram_addr;
  logic [31:0] sram_wr_data, sram_rd_data;
  logic        idle, err;
  logic [15:0] grant_cnt0, grant_cnt1;

  logic [31:0] mem [128];
  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  qracc_sram_arbiter dut (
    .clk(clk), .rst(rst), .mac_busy_i(mac_busy),
    .rq0_valid_i(rq0_valid), .rq0_wr_i(rq0_wr), .rq0_addr_i(rq0_addr),
    .rq0_wr_data_i(rq0_wr_data), .rq0_ready_o(rq0_ready),
    .rq1_valid_i(rq1_valid), .rq1_wr_i(rq1_wr), .rq1_addr_i(rq1_addr),
    .rq1_wr_data_i(rq1_wr_data), .rq1_ready_o(rq1_ready),
    .rd0_valid_o(rd0_valid), .rd0_data_o(rd0_data),
    .rd1_valid_o(rd1_valid), .rd1_data_o(rd1_data),
    .sram_rq_valid_o(sram_rq_valid), .sram_rq_wr_o(sram_rq_wr),
    .sram_addr_o(sram_addr), .sram_wr_data_o(sram_wr_data),
    .sram_rq_ready_i(sram_rq_ready), .sram_rd_valid_i(sram_rd_valid),
    .sram_rd_data_i(sram_rd_data), .idle_o(idle), .err_o(err),
    .grant_cnt0_o(grant_cnt0), .grant_cnt1_o(grant_cnt1)
  );

  typedef struct {
    logic        mac, v0, v1, wr0, wr1;
    logic [6:0]  a0, a1;
    logic [31:0] d0, d1;
    logic        er0, er1;
    logic [31:0] edat;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // SRAM side: entered in S_REQ at a negedge; returns at the negedge where the
  // read pulse (if any) is visible at the outputs.
  task automatic serve(input int lat);
    logic        is_wr;
    logic [6:0]  a;
    logic [31:0] d;
    is_wr = sram_rq_wr;
    a     = sram_addr;
    d     = sram_wr_data;
    repeat (lat) @(negedge clk);
    sram_rq_ready = 1'b1;
    @(negedge clk);
    sram_rq_ready = 1'b0;
    if (is_wr) begin
      mem[a] = d;
    end else begin
      sram_rd_valid = 1'b1;
      sram_rd_data  = mem[a];
      @(negedge clk);
      sram_rd_valid = 1'b0;
      sram_rd_data  = '0;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic        wwr;
    logic [6:0]  wa;
    mac_busy = v.mac;
    rq0_valid = v.v0; rq0_wr = v.wr0; rq0_addr = v.a0; rq0_wr_data = v.d0;
    rq1_valid = v.v1; rq1_wr = v.wr1; rq1_addr = v.a1; rq1_wr_data = v.d1;
    #1;
    chk($sformatf("vec%0d_ready0", idx), {31'b0, rq0_ready}, {31'b0, v.er0});
    chk($sformatf("vec%0d_ready1", idx), {31'b0, rq1_ready}, {31'b0, v.er1});
    if (v.er0 || v.er1) begin
      wwr = v.er1 ? v.wr1 : v.wr0;
      wa  = v.er1 ? v.a1 : v.a0;
      @(negedge clk);
      rq0_valid = 1'b0; rq1_valid = 1'b0;
      chk($sformatf("vec%0d_sram_valid", idx), {31'b0, sram_rq_valid}, 32'd1);
      chk($sformatf("vec%0d_sram_addr", idx), {25'b0, sram_addr}, {25'b0, wa});
      chk($sformatf("vec%0d_sram_wr", idx), {31'b0, sram_rq_wr}, {31'b0, wwr});
      serve(2);
      if (wwr) begin
        chk($sformatf("vec%0d_idle_after_wr", idx), {31'b0, idle}, 32'd1);
      end else begin
        chk($sformatf("vec%0d_rd0_valid", idx), {31'b0, rd0_valid}, {31'b0, v.er0});
        chk($sformatf("vec%0d_rd1_valid", idx), {31'b0, rd1_valid}, {31'b0, v.er1});
        chk($sformatf("vec%0d_rd_data", idx), v.er1 ? rd1_data : rd0_data, v.edat);
        @(negedge clk);
        chk($sformatf("vec%0d_rd_pulse_end", idx), {30'b0, rd1_valid, rd0_valid}, 32'd0);
      end
    end else begin
      repeat (3) begin
        @(negedge clk);
        chk($sformatf("vec%0d_blocked", idx), {29'b0, sram_rq_valid, rq1_ready, rq0_ready}, 32'd0);
      end
      rq0_valid = 1'b0; rq1_valid = 1'b0; mac_busy = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    logic [15:0] exp_cnt;
    for (int i = 0; i < 128; i++) mem[i] = '0;
    //              mac  v0   v1   wr0  wr1  a0  a1  d0            d1            er0  er1  edat
    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 7'd5, 7'd0, 32'hA5A5_0F0F, 32'h0, 1'b1, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 7'd5, 32'h0, 32'h0, 1'b0, 1'b1, 32'hA5A5_0F0F};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 7'd7, 7'd5, 32'h1234_5678, 32'h0, 1'b1, 1'b0, 32'h0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 7'd7, 7'd7, 32'h0, 32'h0, 1'b0, 1'b1, 32'h1234_5678};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'd5, 7'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 7'd0, 7'd3, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'd3, 7'd0, 32'h0, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 7'd5, 7'd3, 32'h0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 7'd5, 7'd7, 32'h0, 32'h0, 1'b1, 1'b0, 32'hA5A5_0F0F};

`ifdef QRACC_SRAM_ARB_GRANT_CNT_EN
    exp_cnt = 16'd3;
`else
    exp_cnt = 16'd0;
`endif

    rst = 1'b1; mac_busy = 1'b0;
    rq0_valid = 1'b0; rq0_wr = 1'b0; rq0_addr = '0; rq0_wr_data = '0;
    rq1_valid = 1'b0; rq1_wr = 1'b0; rq1_addr = '0; rq1_wr_data = '0;
    sram_rq_ready = 1'b0; sram_rd_valid = 1'b0; sram_rd_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_idle", {31'b0, idle}, 32'd1);
    chk("rst_valids", {27'b0, sram_rq_valid, rd0_valid, rd1_valid, rq0_ready, rq1_ready}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_sram_regs", sram_wr_data | {25'b0, sram_addr} | {31'b0, sram_rq_wr}, 32'd0);
    chk("rst_rd_data", rd0_data | rd1_data, 32'd0);
    chk("rst_cnts", {grant_cnt1, grant_cnt0}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // MAC lockout with rq0 pending, then release grants in the same cycle.
    mac_busy = 1'b1; rq0_valid = 1'b1; rq0_wr = 1'b0; rq0_addr = 7'd5;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("lock_blocked", {30'b0, sram_rq_valid, rq0_ready}, 32'd0);
      @(negedge clk);
    end
    mac_busy = 1'b0;
    #1;
    chk("lock_release_ready", {31'b0, rq0_ready}, 32'd1);
    @(negedge clk);
    rq0_valid = 1'b0;
    serve(1);
    chk("lock_rd0", {31'b0, rd0_valid}, 32'd1);
    chk("lock_rd0_data", rd0_data, 32'hA5A5_0F0F);
    @(negedge clk);

    // mac_busy rises while a read is in flight.
    rq1_valid = 1'b1; rq1_wr = 1'b0; rq1_addr = 7'd7;
    #1;
    chk("macrd_ready1", {31'b0, rq1_ready}, 32'd1);
    @(negedge clk);
    rq1_valid = 1'b0; mac_busy = 1'b1; rq0_valid = 1'b1; rq0_addr = 7'd5;
    serve(2);
    chk("macrd_rd1", {30'b0, rd1_valid, rd0_valid}, 32'd2);
    chk("macrd_data", rd1_data, 32'h1234_5678);
    chk("macrd_idle", {31'b0, idle}, 32'd1);
    repeat (3) begin
      @(negedge clk);
      chk("macrd_no_grant", {29'b0, sram_rq_valid, rq1_ready, rq0_ready}, 32'd0);
    end
    rq0_valid = 1'b0; mac_busy = 1'b0;
    @(negedge clk);

    // Spurious read data while idle.
    chk("spur_err_before", {31'b0, err}, 32'd0);
    sram_rd_valid = 1'b1; sram_rd_data = 32'hFFFF_FFFF;
    @(negedge clk);
    sram_rd_valid = 1'b0; sram_rd_data = '0;
    chk("spur_err_set", {31'b0, err}, 32'd1);
    @(negedge clk);
    chk("spur_no_rd", {30'b0, rd1_valid, rd0_valid}, 32'd0);
    repeat (3) @(negedge clk);
    chk("spur_err_sticky", {31'b0, err}, 32'd1);

    // Asynchronous reset while in S_REQ.
    rq0_valid = 1'b1; rq0_wr = 1'b1; rq0_addr = 7'd9; rq0_wr_data = 32'h55;
    @(negedge clk);
    rq0_valid = 1'b0;
    chk("arst_in_req", {31'b0, sram_rq_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid_drop", {31'b0, sram_rq_valid}, 32'd0);
    chk("arst_idle", {31'b0, idle}, 32'd1);
    chk("arst_err_clr", {31'b0, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Continuous contention: strict alternation starting with rq0.
    rq0_valid = 1'b1; rq0_wr = 1'b0; rq0_addr = 7'd5;
    rq1_valid = 1'b1; rq1_wr = 1'b0; rq1_addr = 7'd7;
    for (int i = 0; i < 6; i++) begin
      n = 0;
      #1;
      while (!rq0_ready && !rq1_ready && n < 10) begin
        @(negedge clk);
        #1;
        n++;
      end
      if (n == 10) begin
        failed++;
        tests++;
        $display("FAIL cont_timeout: no grant within 10 cycles at grant %0d", i);
        break;
      end
      chk($sformatf("cont_order%0d", i), {30'b0, rq1_ready, rq0_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
      @(negedge clk);
      serve(1);
      if (i == 5) begin
        rq0_valid = 1'b0; rq1_valid = 1'b0;
      end
      chk($sformatf("cont_rd%0d", i), (i % 2 == 0) ? rd0_data : rd1_data,
          (i % 2 == 0) ? 32'hA5A5_0F0F : 32'h1234_5678);
    end
    @(negedge clk);
    chk("cont_cnt0", {16'b0, grant_cnt0}, {16'b0, exp_cnt});
    chk("cont_cnt1", {16'b0, grant_cnt1}, {16'b0, exp_cnt});
    chk("cont_idle_end", {31'b0, idle}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/qracc_sram_arbiter.md
Name: qracc_sram_arbiter

Overview:
Two-requester arbiter and sequencer for the single request/response port of the QR-accelerator SRAM macro (addr, wr_data, rq_wr, rq_valid, rq_ready, rd_valid, rd_data).
- Requester 0 is the weight loader. Requester 1 is the host/debug readback path.
- Grants are round-robin, one transaction in flight at a time.
- Read data is routed back to its owner.
- All grants are blocked while the MAC engine occupies the array.
- Sits between the requesters and seq_acc's to_sram/from_sram passthrough.

Parameters:
numRows, 128, SRAM rows; address width is $clog2(numRows)
numCols, 32, SRAM word width in bits
cntBits, 16, width of the optional grant counters

Ports:
clk  in  1  clock, all state updates on its rising edge
rst  in  1  asynchronous, active-high reset
mac_busy_i  in  1  MAC engine owns the array; no new grants while high
rq0_valid_i / rq1_valid_i  in  1  requester has a pending request
rq0_wr_i / rq1_wr_i  in  1  1 = write, 0 = read
rq0_addr_i / rq1_addr_i  in  $clog2(numRows)  row address
rq0_wr_data_i / rq1_wr_data_i  in  numCols  write data
rq0_ready_o / rq1_ready_o  out  1  request accepted this cycle
rd0_valid_o / rd1_valid_o  out  1  one-cycle read-data pulse to the owner
rd0_data_o / rd1_data_o  out  numCols  read data, held until the next read completes
sram_rq_valid_o  out  1  request to SRAM
sram_rq_wr_o  out  1  registered rq_wr
sram_addr_o  out  $clog2(numRows)  registered address
sram_wr_data_o  out  numCols  registered write data
sram_rq_ready_i  in  1  SRAM accepts the request
sram_rd_valid_i  in  1  SRAM read data valid
sram_rd_data_i  in  numCols  SRAM read data
idle_o  out  1  FSM in S_IDLE; MAC controller may start
err_o  out  1  sticky flag: unexpected sram_rd_valid_i
grant_cnt0_o / grant_cnt1_o  out  cntBits  grant counters (optional feature)

Behaviour:
Reset values (asynchronous on rst):
- FSM = S_IDLE, idle_o = 1.
- All *_valid_o, *_ready_o, err_o, counters = 0; data/address registers = 0.
- Round-robin pointer last_grant = 1, so requester 0 wins the first tie.

S_IDLE:
- Grant is combinational: grant only if !mac_busy_i and at least one rqN_valid_i.
- If both requesters are valid, grant the one not equal to last_grant.
- Winner's rqN_ready_o = 1 in the same cycle (valid&ready handshake). The loser's ready stays 0.
- On that edge: capture wr/addr/wr_data into the sram_* registers, record owner, update last_grant, go to S_REQ.

S_REQ:
- sram_rq_valid_o = 1; the sram_* outputs are held stable.
- On sram_rq_ready_i: drop sram_rq_valid_o next cycle. Go to S_IDLE if it was a write, S_RD if it was a read.

S_RD:
- Wait for sram_rd_valid_i, with no timeout.
- On the cycle after it: rdN_valid_o = 1 for exactly one cycle on the owner only, and rdN_data_o = the captured sram_rd_data_i. Go to S_IDLE on that same edge.

Latency:
- Handshake at cycle T → sram_rq_valid_o high from T+1.
- Minimum write occupancy: 2 cycles.
- Read data reaches the owner 1 cycle after sram_rd_valid_i.
- Back-to-back grants: the next grant is possible in the cycle after returning to S_IDLE.

Boundaries:
- mac_busy_i asserting in S_REQ/S_RD does not abort; the in-flight transaction completes and no new grant is issued.
- mac_busy_i high in S_IDLE: both ready outputs = 0 and requests stay pending.
- sram_rd_valid_i in S_IDLE or S_REQ: ignored for routing and sets err_o. err_o clears only on rst.
- A requester deasserting valid without a handshake: no effect.
- rst mid-transaction: immediate return to reset values; the pending SRAM request is dropped.
- idle_o = (state == S_IDLE).

Optional Feature:
Macro QRACC_SRAM_ARB_GRANT_CNT_EN.
- Defined: grant_cnt0_o/grant_cnt1_o increment by 1 on each handshake of the respective requester, saturating at 2^cntBits-1. Cleared only on rst.
- Undefined: both outputs tied to 0 and no counter flops are synthesized.

Test Plan:
- Write, then read: rq0 writes addr 5 = 0xA5A5_0F0F; SRAM model gives ready after 2 cycles. Then rq1 reads addr 5 → rd1_valid_o single pulse with 0xA5A5_0F0F; rd0_valid_o stays 0.
- Contention: rq0 and rq1 both valid continuously for 6 reads → grant order 0,1,0,1,0,1. With the feature on, grant_cnt0_o = grant_cnt1_o = 3.
- MAC lockout: mac_busy_i = 1 while rq0 is valid for 10 cycles → rq0_ready_o = 0 and sram_rq_valid_o = 0 throughout. Deassert → grant in that cycle.
- mac_busy_i rises during S_RD → read completes, data delivered, idle_o = 1, no further grant.
- Spurious sram_rd_valid_i in S_IDLE → err_o = 1 and stays 1. No rdN_valid_o pulse.
- rst pulse while in S_REQ → sram_rq_valid_o = 0 and idle_o = 1 immediately (asynchronous). Afterwards rq0 wins the first tie.
